// File: rtl/port_bus_target_pkg.sv
// Shared definitions for the Tiny DSP port bus responder: state encodings
// and default widths that follow the core's data and port fields.
package port_bus_target_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_ADDR  = 3'd1,
    T_READ  = 3'd2,
    T_WRITE = 3'd3,
    T_WHOLD = 3'd4,
    T_WAIT  = 3'd5
  } state_e;

endpackage

// File: rtl/port_bus_target_if.sv
// Port bus strobes, address and data shared by the core-side master and
// the peripheral-side target.
interface port_bus_target_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  logic              as;
  logic              read;
  logic              write;
  logic              write_h;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output as, read, write, write_h, address, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  as, read, write, write_h, address, bus_wdata,
    output bus_rdata
  );

endinterface

// File: rtl/port_bus_target_regs.sv
// Port register bank with read-only masking and the read source mux;
// read-only ports never store data and read back their peripheral input.
module port_bus_target_regs
  import port_bus_target_pkg::*;
#(
  parameter int                   DATA_W    = DEF_DATA_W,
  parameter int                   ADDR_W    = DEF_ADDR_W,
  parameter int                   NUM_PORTS = 8,
  parameter logic [NUM_PORTS-1:0] RO_MASK   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we_i,
  input  logic [ADDR_W-1:0]             wr_idx_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic [ADDR_W-1:0]             rd_idx_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_in_i,
  output logic [NUM_PORTS*DATA_W-1:0]   port_out_o,
  output logic [DATA_W-1:0]             rd_data_o,
  output logic                          writable_o
);

  logic [NUM_PORTS*DATA_W-1:0] regs_q;

  // Unmapped indices match no port, so they read as zero and are never writable.
  always_comb begin
    rd_data_o  = '0;
    writable_o = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (int'(rd_idx_i) == i)
        rd_data_o = RO_MASK[i] ? port_in_i[i*DATA_W +: DATA_W] : regs_q[i*DATA_W +: DATA_W];
      if (int'(wr_idx_i) == i)
        writable_o = !RO_MASK[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (we_i && !RO_MASK[i] && int'(wr_idx_i) == i)
          regs_q[i*DATA_W +: DATA_W] <= wr_data_i;
      end
    end
  end

  assign port_out_o = regs_q;

endmodule

// File: rtl/port_bus_target.sv
// Responder end of the Tiny DSP port bus: decodes the strobe sequence,
// returns read data and commits writes into the port register bank.
module port_bus_target
  import port_bus_target_pkg::*;
#(
  parameter int                   DATA_W    = DEF_DATA_W,
  parameter int                   ADDR_W    = DEF_ADDR_W,
  parameter int                   NUM_PORTS = 8,
  parameter logic [NUM_PORTS-1:0] RO_MASK   = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  port_bus_target_if.slave            bus,
  input  logic [NUM_PORTS*DATA_W-1:0] port_in,
  output logic [NUM_PORTS*DATA_W-1:0] port_out,
  output logic [NUM_PORTS-1:0]        wr_pulse,
  output logic [NUM_PORTS-1:0]        rd_pulse,
  input  logic                        clr_err,
  output logic                        proto_err
);

  state_e                state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [NUM_PORTS-1:0]  wr_pulse_q;
  logic [NUM_PORTS-1:0]  rd_pulse_q;
  logic                  err_q;

  logic                  commit_d;
  logic                  err_set_d;
  logic                  addr_mapped;
  logic                  writable;
  logic [DATA_W-1:0]     src_data;
  logic [NUM_PORTS-1:0]  addr_onehot;

  assign addr_mapped = int'(bus.address) < NUM_PORTS;
  assign addr_onehot = NUM_PORTS'(1) << addr_q;
  assign commit_d    = (state_q == T_WRITE) && !bus.write && bus.write_h;

  always_comb begin
    err_set_d = 1'b0;
    case (state_q)
      T_IDLE:  err_set_d = bus.as ? !addr_mapped : (bus.read | bus.write);
      T_ADDR:  err_set_d = bus.read & bus.write;
      T_WRITE: err_set_d = !bus.write_h;
      default: err_set_d = 1'b0;
    endcase
  end

  port_bus_target_regs #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_PORTS (NUM_PORTS),
    .RO_MASK   (RO_MASK)
  ) u_regs (
    .clk        (clk),
    .reset      (reset),
    .we_i       (commit_d),
    .wr_idx_i   (addr_q),
    .wr_data_i  (bus.bus_wdata),
    .rd_idx_i   (bus.address),
    .port_in_i  (port_in),
    .port_out_o (port_out),
    .rd_data_o  (src_data),
    .writable_o (writable)
  );

  // Read data is captured at the address strobe so it is ready one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= T_IDLE;
      addr_q     <= '0;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      if (err_set_d)
        err_q <= 1'b1;
      else if (clr_err)
        err_q <= 1'b0;
      case (state_q)
        T_IDLE: begin
          if (bus.as) begin
            state_q <= T_ADDR;
            addr_q  <= bus.address;
            rdata_q <= src_data;
          end
        end
        T_ADDR: begin
          if (bus.read && bus.write) begin
            state_q <= T_WAIT;
          end else if (bus.read) begin
            state_q    <= T_READ;
            rd_pulse_q <= addr_onehot;
          end else if (bus.write && bus.write_h) begin
            state_q <= T_WRITE;
          end else if (!bus.as) begin
            state_q <= T_IDLE;
          end
        end
        T_READ:  state_q <= T_WAIT;
        T_WRITE: begin
          if (!bus.write_h) begin
            state_q <= T_WAIT;
          end else if (!bus.write) begin
            state_q <= T_WHOLD;
            if (writable)
              wr_pulse_q <= addr_onehot;
          end
        end
        T_WHOLD: state_q <= T_WAIT;
        T_WAIT: begin
          if (!bus.as) begin
            state_q <= T_IDLE;
            rdata_q <= '0;
          end
        end
        default: state_q <= T_IDLE;
      endcase
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign wr_pulse      = wr_pulse_q;
  assign rd_pulse      = rd_pulse_q;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_port_bus_target.sv
// Directed bench for port_bus_target: an 8-port instance with port 7
// read-only and a 6-port instance for unmapped-address behaviour.
module tb_port_bus_target;
  import port_bus_target_pkg::*;

  logic          clk;
  logic          reset;
  logic          as;
  logic          rd;
  logic          wr;
  logic          wrH;
  logic [2:0]    addr;
  logic [15:0]   wdata;
  logic          clrErr;

  logic [127:0]  portIn8;
  logic [95:0]   portIn6;
  logic [127:0]  portOut8;
  logic [95:0]   portOut6;
  logic [7:0]    wrPulse8;
  logic [7:0]    rdPulse8;
  logic [5:0]    wrPulse6;
  logic [5:0]    rdPulse6;
  logic          err8;
  logic          err6;

  logic [127:0]  expPort8;
  logic [95:0]   expPort6;

  int            assertCount;
  int            failCount;

  port_bus_target_if #(.DATA_W(16), .ADDR_W(3)) bus8 ();
  port_bus_target_if #(.DATA_W(16), .ADDR_W(3)) bus6 ();

  assign bus8.as        = as;
  assign bus8.read      = rd;
  assign bus8.write     = wr;
  assign bus8.write_h   = wrH;
  assign bus8.address   = addr;
  assign bus8.bus_wdata = wdata;
  assign bus6.as        = as;
  assign bus6.read      = rd;
  assign bus6.write     = wr;
  assign bus6.write_h   = wrH;
  assign bus6.address   = addr;
  assign bus6.bus_wdata = wdata;

  port_bus_target #(
    .DATA_W(16), .ADDR_W(3), .NUM_PORTS(8), .RO_MASK(8'h80)
  ) dut8 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus8.slave),
    .port_in   (portIn8),
    .port_out  (portOut8),
    .wr_pulse  (wrPulse8),
    .rd_pulse  (rdPulse8),
    .clr_err   (clrErr),
    .proto_err (err8)
  );

  port_bus_target #(
    .DATA_W(16), .ADDR_W(3), .NUM_PORTS(6), .RO_MASK(6'b000000)
  ) dut6 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus6.slave),
    .port_in   (portIn6),
    .port_out  (portOut6),
    .wr_pulse  (wrPulse6),
    .rd_pulse  (rdPulse6),
    .clr_err   (clrErr),
    .proto_err (err6)
  );

  always #5 clk = ~clk;

  // Drive one bus cycle, then land 1 time unit past the edge that consumed it.
  task automatic applyStimulus(input logic a, input logic r, input logic w,
                               input logic wh, input logic [2:0] ad, input logic [15:0] d);
    as = a; rd = r; wr = w; wrH = wh; addr = ad; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    clk    = 1'b0;
    reset  = 1'b1;
    as = 1'b0; rd = 1'b0; wr = 1'b0; wrH = 1'b0; addr = '0; wdata = '0;
    clrErr = 1'b0;
    portIn8 = '0;
    portIn8[7*16 +: 16] = 16'h1234;
    portIn8[2*16 +: 16] = 16'hDEAD;
    portIn6  = {6{16'hBEEF}};
    expPort8 = '0;
    expPort6 = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rdata8", 128'(bus8.bus_rdata), 128'h0);
    checkOutput("reset_portout8", portOut8, 128'h0);
    checkOutput("reset_pulses8", {wrPulse8, rdPulse8}, 128'h0);
    checkOutput("reset_err", {err8, err6}, 128'h0);
    checkOutput("reset_state8", 128'(dut8.state_q), 128'(T_IDLE));
    reset = 1'b0;

    $display("[TB] write port 2 = A5C3");
    applyStimulus(1, 0, 0, 0, 3'd2, 16'h0);
    applyStimulus(1, 0, 1, 1, 3'd2, 16'hA5C3);
    checkOutput("wr2_precommit", portOut8, expPort8);
    applyStimulus(1, 0, 0, 1, 3'd2, 16'hA5C3);
    expPort8[2*16 +: 16] = 16'hA5C3;
    expPort6[2*16 +: 16] = 16'hA5C3;
    checkOutput("wr2_portout8", portOut8, expPort8);
    checkOutput("wr2_portout6", 128'(portOut6), 128'(expPort6));
    checkOutput("wr2_pulse8", 128'(wrPulse8), 128'h04);
    checkOutput("wr2_pulse6", 128'(wrPulse6), 128'h04);
    applyStimulus(0, 0, 0, 0, 3'd2, 16'h0);
    checkOutput("wr2_pulse_gone", 128'(wrPulse8), 128'h0);
    applyStimulus(0, 0, 0, 0, 3'd0, 16'h0);
    checkOutput("wr2_no_err", {err8, err6}, 128'h0);

    $display("[TB] read port 2");
    applyStimulus(1, 0, 0, 0, 3'd2, 16'h0);
    checkOutput("rd2_rdata8", 128'(bus8.bus_rdata), 128'hA5C3);
    checkOutput("rd2_rdata6", 128'(bus6.bus_rdata), 128'hA5C3);
    applyStimulus(1, 1, 0, 0, 3'd2, 16'h0);
    checkOutput("rd2_pulse8", 128'(rdPulse8), 128'h04);
    checkOutput("rd2_rdata_hold", 128'(bus8.bus_rdata), 128'hA5C3);
    applyStimulus(1, 0, 0, 0, 3'd2, 16'h0);
    checkOutput("rd2_pulse_gone", 128'(rdPulse8), 128'h0);
    applyStimulus(0, 0, 0, 0, 3'd2, 16'h0);
    checkOutput("rd2_rdata_clr", 128'(bus8.bus_rdata), 128'h0);

    $display("[TB] read port 7: read-only on dut8, unmapped on dut6");
    applyStimulus(1, 0, 0, 0, 3'd7, 16'h0);
    checkOutput("rd7_rdata8", 128'(bus8.bus_rdata), 128'h1234);
    checkOutput("rd7_rdata6", 128'(bus6.bus_rdata), 128'h0);
    checkOutput("rd7_err", {err8, err6}, 128'h1);
    applyStimulus(1, 1, 0, 0, 3'd7, 16'h0);
    checkOutput("rd7_pulse8", 128'(rdPulse8), 128'h80);
    checkOutput("rd7_pulse6", 128'(rdPulse6), 128'h0);
    applyStimulus(1, 0, 0, 0, 3'd7, 16'h0);
    applyStimulus(0, 0, 0, 0, 3'd7, 16'h0);
    clrErr = 1'b1;
    applyStimulus(0, 0, 0, 0, 3'd0, 16'h0);
    clrErr = 1'b0;
    checkOutput("rd7_err_cleared", 128'(err6), 128'h0);

    $display("[TB] write FFFF to port 7");
    applyStimulus(1, 0, 0, 0, 3'd7, 16'h0);
    applyStimulus(1, 0, 1, 1, 3'd7, 16'hFFFF);
    applyStimulus(1, 0, 0, 1, 3'd7, 16'hFFFF);
    checkOutput("wr7_pulse", {wrPulse8, wrPulse6}, 128'h0);
    checkOutput("wr7_portout8", portOut8, expPort8);
    checkOutput("wr7_portout6", 128'(portOut6), 128'(expPort6));
    checkOutput("wr7_err", {err8, err6}, 128'h1);
    applyStimulus(0, 0, 0, 0, 3'd7, 16'h0);
    applyStimulus(0, 0, 0, 0, 3'd0, 16'h0);
    clrErr = 1'b1;
    applyStimulus(0, 0, 0, 0, 3'd0, 16'h0);
    clrErr = 1'b0;

    $display("[TB] protocol fault: write without address strobe");
    applyStimulus(0, 0, 1, 0, 3'd0, 16'h0);
    checkOutput("f1_err", 128'(err8), 128'h1);
    checkOutput("f1_state", 128'(dut8.state_q), 128'(T_IDLE));
    clrErr = 1'b1;
    applyStimulus(0, 0, 1, 0, 3'd0, 16'h0);
    checkOutput("f1_set_wins", 128'(err8), 128'h1);
    applyStimulus(0, 0, 0, 0, 3'd0, 16'h0);
    clrErr = 1'b0;
    checkOutput("f1_clear", 128'(err8), 128'h0);
    checkOutput("f1_portout", portOut8, expPort8);

    $display("[TB] protocol fault: read and write together");
    applyStimulus(1, 0, 0, 0, 3'd3, 16'h0);
    applyStimulus(1, 1, 1, 1, 3'd3, 16'h5555);
    checkOutput("f2_err", 128'(err8), 128'h1);
    checkOutput("f2_no_rdpulse", 128'(rdPulse8), 128'h0);
    applyStimulus(0, 0, 0, 0, 3'd3, 16'h0);
    checkOutput("f2_state", 128'(dut8.state_q), 128'(T_IDLE));
    checkOutput("f2_portout", portOut8, expPort8);
    clrErr = 1'b1;
    applyStimulus(0, 0, 0, 0, 3'd0, 16'h0);
    clrErr = 1'b0;

    $display("[TB] protocol fault: write_h dropped with write");
    applyStimulus(1, 0, 0, 0, 3'd3, 16'h0);
    applyStimulus(1, 0, 1, 1, 3'd3, 16'hBEEF);
    applyStimulus(1, 0, 0, 0, 3'd3, 16'hBEEF);
    checkOutput("f3_err", 128'(err8), 128'h1);
    checkOutput("f3_no_wrpulse", 128'(wrPulse8), 128'h0);
    applyStimulus(0, 0, 0, 0, 3'd3, 16'h0);
    checkOutput("f3_state", 128'(dut8.state_q), 128'(T_IDLE));
    checkOutput("f3_portout", portOut8, expPort8);

    $display("[TB] reset during write of 00FF to port 1");
    applyStimulus(1, 0, 0, 0, 3'd1, 16'h0);
    as = 1'b1; rd = 1'b0; wr = 1'b1; wrH = 1'b1; addr = 3'd1; wdata = 16'h00FF;
    #2;
    reset = 1'b1;
    #1;
    expPort8 = '0;
    checkOutput("rst_portout8", portOut8, expPort8);
    checkOutput("rst_err8", 128'(err8), 128'h0);
    checkOutput("rst_rdata8", 128'(bus8.bus_rdata), 128'h0);
    @(posedge clk);
    #1;
    as = 1'b0; wr = 1'b0; wrH = 1'b0; wdata = '0;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1, 3'd1, 16'h00FF);
    applyStimulus(0, 0, 0, 0, 3'd0, 16'h0);
    checkOutput("rst_port1_stays0", portOut8, expPort8);
    checkOutput("rst_state", 128'(dut8.state_q), 128'(T_IDLE));
    checkOutput("rst_pulses", {wrPulse8, rdPulse8}, 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
